// File: rtl/hint_evaluator_pkg.sv
// Shared widths, sizes and FSM state encoding for the Mastermind hint evaluator.
package hint_evaluator_pkg;

  localparam int PIN_COLOR_W    = 5;
  localparam int PIN_POS_W      = 5;
  localparam int max_pins_count = 20;

  typedef enum logic [1:0] {
    HE_IDLE,
    HE_GREEN,
    HE_YELLOW,
    HE_FIN
  } HINT_EVAL_STATE;

endpackage

// File: rtl/pin_select.sv
// Indexed colour mux: returns the colour of one pin from a packed pin vector.
// Indices outside the vector return colour 0.
module pin_select
  import hint_evaluator_pkg::*;
#(
  parameter int MAX_PINS = max_pins_count,
  parameter int COLOR_W  = PIN_COLOR_W,
  parameter int POS_W    = PIN_POS_W
) (
  input  logic [MAX_PINS*COLOR_W-1:0] pins,
  input  logic [POS_W-1:0]            idx,
  output logic [COLOR_W-1:0]          color
);

  // Plain one-hot style mux over every pin slot.
  always_comb begin
    color = '0;
    for (int k = 0; k < MAX_PINS; k++) begin
      if (idx == POS_W'(k)) begin
        color = pins[k*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/hint_evaluator.sv
// Sequential Mastermind scorer: one pin comparison per cycle through a single
// shared colour comparator, producing green and yellow hint counts.
module hint_evaluator
  import hint_evaluator_pkg::*;
#(
  parameter int MAX_PINS = max_pins_count,
  parameter int COLOR_W  = PIN_COLOR_W,
  parameter int POS_W    = PIN_POS_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [POS_W-1:0]            pins_count,
  input  logic [MAX_PINS*COLOR_W-1:0] guess,
  input  logic [MAX_PINS*COLOR_W-1:0] secret,
  output logic                        busy,
  output logic                        done,
  output logic [POS_W-1:0]            green,
  output logic [POS_W-1:0]            yellow,
  output logic [MAX_PINS-1:0]         analyzed_guess,
  output logic [MAX_PINS-1:0]         analyzed_secret
);

  HINT_EVAL_STATE state, state_d;

  logic [MAX_PINS*COLOR_W-1:0] guess_q, secret_q;
  logic [POS_W-1:0]            n_q, i_q, j_q;
  logic [POS_W-1:0]            i_d, j_d, green_d, yellow_d;
  logic [MAX_PINS-1:0]         ag_d, as_d;
  logic [POS_W-1:0]            n_clamped, n_last, s_idx;
  logic [COLOR_W-1:0]          g_pin, s_pin;
  logic                        colors_match;
  logic                        advance_i;

  assign n_clamped    = (pins_count > POS_W'(MAX_PINS)) ? POS_W'(MAX_PINS) : pins_count;
  assign n_last       = n_q - POS_W'(1);
  assign s_idx        = (state == HE_GREEN) ? i_q : j_q;
  assign colors_match = (g_pin == s_pin);

  pin_select #(
    .MAX_PINS (MAX_PINS),
    .COLOR_W  (COLOR_W),
    .POS_W    (POS_W)
  ) u_guess_sel (
    .pins  (guess_q),
    .idx   (i_q),
    .color (g_pin)
  );

  pin_select #(
    .MAX_PINS (MAX_PINS),
    .COLOR_W  (COLOR_W),
    .POS_W    (POS_W)
  ) u_secret_sel (
    .pins  (secret_q),
    .idx   (s_idx),
    .color (s_pin)
  );

  // Next-state and datapath updates: greens first, then a j-scan per guess pin for yellows.
  always_comb begin
    state_d   = state;
    i_d       = i_q;
    j_d       = j_q;
    green_d   = green;
    yellow_d  = yellow;
    ag_d      = analyzed_guess;
    as_d      = analyzed_secret;
    advance_i = 1'b0;

    case (state)
      HE_IDLE: begin
        if (start) begin
          green_d  = '0;
          yellow_d = '0;
          ag_d     = '0;
          as_d     = '0;
          i_d      = '0;
          j_d      = '0;
          state_d  = (n_clamped == '0) ? HE_FIN : HE_GREEN;
        end
      end

      HE_GREEN: begin
        if (colors_match) begin
          green_d     = green + POS_W'(1);
          ag_d[i_q]   = 1'b1;
          as_d[i_q]   = 1'b1;
        end
        if (i_q == n_last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = HE_YELLOW;
        end else begin
          i_d = i_q + POS_W'(1);
        end
      end

      HE_YELLOW: begin
        if (analyzed_guess[i_q]) begin
          advance_i = 1'b1;
        end else if (!analyzed_secret[j_q] && colors_match) begin
          yellow_d  = yellow + POS_W'(1);
          as_d[j_q] = 1'b1;
          ag_d[i_q] = 1'b1;
          advance_i = 1'b1;
        end else if (j_q == n_last) begin
          advance_i = 1'b1;
        end else begin
          j_d = j_q + POS_W'(1);
        end

        if (advance_i) begin
          j_d = '0;
          if (i_q == n_last) begin
            state_d = HE_FIN;
          end else begin
            i_d = i_q + POS_W'(1);
          end
        end
      end

      HE_FIN: begin
        state_d = HE_IDLE;
      end

      default: begin
        state_d = HE_IDLE;
      end
    endcase
  end

  // State, latched operands, counters and the registered busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HE_IDLE;
      guess_q         <= '0;
      secret_q        <= '0;
      n_q             <= '0;
      i_q             <= '0;
      j_q             <= '0;
      green           <= '0;
      yellow          <= '0;
      analyzed_guess  <= '0;
      analyzed_secret <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_d;
      i_q             <= i_d;
      j_q             <= j_d;
      green           <= green_d;
      yellow          <= yellow_d;
      analyzed_guess  <= ag_d;
      analyzed_secret <= as_d;
      busy            <= (state == HE_GREEN) || (state == HE_YELLOW);
      done            <= (state == HE_FIN);
      if ((state == HE_IDLE) && start) begin
        guess_q  <= guess;
        secret_q <= secret;
        n_q      <= n_clamped;
      end
    end
  end

endmodule
